hazard_unit: RTL and testbench
==============================

# hazard_unit

Parametrised pipeline hazard controller for the four-stage MIPS core (fetch/decode/execute/memory). It replaces the tied-off global stall with real load-use stalls, ME→EX operand forwarding selects, and redirect flushes. It also adds a multi-cycle multiply/divide (MDU) busy tracker that stalls dependent instructions for a configurable latency. It sits beside the stage modules in `mips` and drives their stall/flush inputs; `AnyStall` becomes its output.

## Interface
- `REG_W`, 5, register-index width
- `MDU_LAT`, 4, MDU result latency in cycles (≥1)
- `CNT_W`, 16, width of performance counters (only with `HAZARD_PERF_EN`)

- `clk` in 1 — core clock, rising edge
- `reset` in 1 — asynchronous, active-low reset
- `Rs_ID`, `Rt_ID` in REG_W — source registers of the instruction in ID
- `UsesRt_ID` in 1 — the ID instruction reads Rt as an operand
- `MduUse_ID` in 1 — the ID instruction reads HI/LO or issues an MDU op
- `Rs_EX`, `Rt_EX` in REG_W — source registers of the instruction in EX
- `WriteReg_EX` in REG_W; `RegWrite_EX`, `MemToReg_EX` in 1 — EX destination and its type
- `WriteReg_ME` in REG_W; `RegWrite_ME` in 1 — ME destination
- `MduStart_EX` in 1 — an MDU op is in EX this cycle
- `Jump_ID` in 1 — jump resolved in ID
- `BranchTaken_EX` in 1 — taken branch resolved in EX
- `Stall_IF`, `Stall_ID` out 1 — hold the PC / hold the IF/ID register
- `Flush_ID` out 1 — bubble the IF/ID register
- `Flush_EX` out 1 — bubble the ID/EX register
- `FwdA_EX`, `FwdB_EX` out 2 — operand select: 00 = register file, 01 = ME result, others reserved
- `MduBusy` out 1 — MDU op in flight
- `AnyStall` out 1 — equals `Stall_ID`
- `StallCnt`, `FlushCnt` out CNT_W — present only with `HAZARD_PERF_EN`

## Operation
- **Load-use:** `LoadUse = RegWrite_EX & MemToReg_EX & (WriteReg_EX != 0) & (WriteReg_EX == Rs_ID | (UsesRt_ID & WriteReg_EX == Rt_ID))`. It asserts `Stall_IF`, `Stall_ID` and `Flush_EX` for that cycle.
- **Forwarding:** `FwdA_EX = 01` iff `RegWrite_ME & WriteReg_ME != 0 & WriteReg_ME == Rs_EX`, else `00`. `FwdB_EX` follows the same rule using `Rt_EX`.
- **Redirect:**
  - `Jump_ID` asserts `Flush_ID`.
  - `BranchTaken_EX` asserts `Flush_ID` and `Flush_EX`.
  - Branch flush has priority: when `BranchTaken_EX` is set, all stall outputs are forced to 0, because the ID instruction is on the wrong path.
- **MDU FSM:** states IDLE and BUSY, with a down-counter of width `$clog2(MDU_LAT)`.
  - IDLE → BUSY on `MduStart_EX` when `MDU_LAT > 1`; the counter loads `MDU_LAT-1`.
  - BUSY: the counter decrements each cycle; on reaching 1 the FSM returns to IDLE at the next edge.
  - `MduBusy = (state == BUSY)`.
  - `MduUse_ID & MduBusy` asserts `Stall_IF`, `Stall_ID` and `Flush_EX`.
  - `MDU_LAT = 1`: the FSM never leaves IDLE.
  - `MduStart_EX` while BUSY cannot occur, because the dependent stall prevents it. If it does occur, the counter reloads.
  - Flushes never cancel an in-flight MDU op.
- Simultaneous load-use and MDU stall produce one combined stall; the outputs are an OR.

## Timing
- All stall, flush and forward outputs are combinational from the current-cycle inputs and the registered FSM state; there is no added latency.
- A load-use stall lasts exactly 1 cycle.
- An MDU stall lasts until `MduBusy` falls: at most `MDU_LAT-1` cycles after `MduStart_EX`.
- The MDU state and counters update on the rising `clk` edge.
- While `reset` is low: state = IDLE, counter = 0, `MduBusy = 0`, and perf counters = 0. All combinational outputs then read 0 except where inputs demand otherwise; during reset the stage modules hold their own registers.
- Reset asserted mid-BUSY aborts immediately, with no stall after release.

## Configuration
- Macro: `HAZARD_PERF_EN`.
- **Defined:**
  - `StallCnt` increments on every cycle with `Stall_ID = 1`.
  - `FlushCnt` increments on every cycle with `Flush_ID | Flush_EX`.
  - Both saturate at `2^CNT_W-1` and reset to 0.
- **Undefined:** the counters and ports are absent, and the behaviour is otherwise identical.

## Structure
- Shared package `mips_pkg` holds:
  - the forward-select constants `FWD_RF = 2'b00` and `FWD_ME = 2'b01`;
  - the MDU state enum `{MDU_IDLE, MDU_BUSY}`.
- Sub-module `mdu_tracker` (parameter `MDU_LAT`, ports `clk`, `reset`, `start`, `busy`) holds the FSM and counter. The forwarding and stall logic stays in `hazard_unit`.

## Test plan
- `lw $2` in EX (`RegWrite_EX = 1`, `MemToReg_EX = 1`, `WriteReg_EX = 2`), `Rs_ID = 2` → `Stall_IF = Stall_ID = Flush_EX = 1` for 1 cycle. With `WriteReg_EX = 0` → no stall.
- `RegWrite_ME = 1`, `WriteReg_ME = 5`, `Rs_EX = 5`, `Rt_EX = 5` → `FwdA_EX = FwdB_EX = 01`. With `WriteReg_ME = 0` → both `00`.
- `BranchTaken_EX = 1` together with a load-use condition → `Flush_ID = Flush_EX = 1`, `Stall_ID = 0`. `Jump_ID` alone → only `Flush_ID = 1`.
- `MDU_LAT = 4`: `MduStart_EX` pulse, then `MduUse_ID = 1` held → `MduBusy` high for 3 cycles, stall for 3 cycles, released on the 4th.
- Reset (`reset = 0`) asserted during BUSY → `MduBusy = 0` immediately. After release, `MduUse_ID = 1` → no stall.
- `HAZARD_PERF_EN`, `CNT_W = 2`: 5 stall cycles → `StallCnt = 3` (saturated). 1 jump flush → `FlushCnt = 1`.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the four-stage MIPS core
//               hazard logic: operand forward selects and the MDU tracker
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Operand select for the EX-stage ALU inputs
    localparam logic [1:0] FWD_RF = 2'b00;  // value read from the register file
    localparam logic [1:0] FWD_ME = 2'b01;  // value bypassed from the ME stage

    // Multiply/divide unit occupancy
    typedef enum logic [0:0] {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/hazard_unit_mdu_tracker.sv
`default_nettype none
// ============================================================================
// Module      : mdu_tracker
// Description : Tracks an in-flight multi-cycle multiply/divide operation.
//               A start pulse in EX opens a busy window of MDU_LAT-1 cycles
//               during which dependent instructions must wait. With
//               MDU_LAT = 1 the result is ready in time and the tracker
//               stays idle.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_tracker
    import mips_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic clk,
    input  logic reset,     // asynchronous, active low
    input  logic start,
    output logic busy
);

    // A one-bit counter is kept even when MDU_LAT = 1 so no zero-width
    // vector is ever declared; it simply never leaves zero in that case.
    localparam int unsigned CNT_W_L  = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [CNT_W_L-1:0] C_LOAD = CNT_W_L'(MDU_LAT - 1);
    localparam logic [CNT_W_L-1:0] C_ONE  = CNT_W_L'(1);

    mdu_state_e           state_q, state_d;
    logic [CNT_W_L-1:0]   cnt_q,   cnt_d;

    // Next-state and counter update; a start seen while busy reloads the
    // window, flushes are deliberately not an input here.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MDU_IDLE: begin
                if ((MDU_LAT > 1) && start) begin
                    state_d = MDU_BUSY;
                    cnt_d   = C_LOAD;
                end
            end
            MDU_BUSY: begin
                if (start) begin
                    cnt_d   = C_LOAD;
                end else if (cnt_q == C_ONE) begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - C_ONE;
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset aborts any in-flight operation immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == MDU_BUSY);

endmodule : mdu_tracker
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard controller for the four-stage MIPS core.
//               Generates load-use and MDU-dependency stalls, ME->EX operand
//               forward selects and redirect flushes. All control outputs
//               are combinational from the current inputs and the MDU
//               tracker state.
//               Optional build macro HAZARD_PERF_EN adds saturating
//               stall/flush performance counters (StallCnt, FlushCnt).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import mips_pkg::*;
#(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,          // asynchronous, active low
    // ID stage
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    input  logic             UsesRt_ID,
    input  logic             MduUse_ID,
    // EX stage
    input  logic [REG_W-1:0] Rs_EX,
    input  logic [REG_W-1:0] Rt_EX,
    input  logic [REG_W-1:0] WriteReg_EX,
    input  logic             RegWrite_EX,
    input  logic             MemToReg_EX,
    // ME stage
    input  logic [REG_W-1:0] WriteReg_ME,
    input  logic             RegWrite_ME,
    // MDU / redirect
    input  logic             MduStart_EX,
    input  logic             Jump_ID,
    input  logic             BranchTaken_EX,
    // Controls to the stage registers
    output logic             Stall_IF,
    output logic             Stall_ID,
    output logic             Flush_ID,
    output logic             Flush_EX,
    output logic [1:0]       FwdA_EX,
    output logic [1:0]       FwdB_EX,
    output logic             MduBusy,
    output logic             AnyStall
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    localparam logic [REG_W-1:0] C_REG_ZERO = '0;

    logic w_load_use;
    logic w_mdu_stall;
    logic w_stall;
    logic w_mdu_busy;

    // ------------------------------------------------------------------
    // MDU occupancy tracker
    // ------------------------------------------------------------------
    mdu_tracker #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu_tracker (
        .clk   (clk),
        .reset (reset),
        .start (MduStart_EX),
        .busy  (w_mdu_busy)
    );

    // Hazard detection: a load in EX feeding the ID instruction, or an ID
    // instruction that needs an MDU result still being computed. A taken
    // branch kills the ID instruction, so its stall is meaningless and
    // suppressed; both stall sources merge into a single stall.
    always_comb begin
        w_load_use  = RegWrite_EX && MemToReg_EX && (WriteReg_EX != C_REG_ZERO) &&
                      ((WriteReg_EX == Rs_ID) || (UsesRt_ID && (WriteReg_EX == Rt_ID)));
        w_mdu_stall = MduUse_ID && w_mdu_busy;
        w_stall     = (w_load_use || w_mdu_stall) && !BranchTaken_EX;
    end

    // Stall and flush controls: a stall holds PC and IF/ID while the ID/EX
    // register receives a bubble; redirects squash the younger stages.
    always_comb begin
        Stall_IF = w_stall;
        Stall_ID = w_stall;
        AnyStall = w_stall;
        Flush_ID = Jump_ID || BranchTaken_EX;
        Flush_EX = BranchTaken_EX || w_stall;
        MduBusy  = w_mdu_busy;
    end

    // ME->EX operand bypass; $0 is never forwarded since it reads as zero.
    always_comb begin
        FwdA_EX = FWD_RF;
        FwdB_EX = FWD_RF;
        if (RegWrite_ME && (WriteReg_ME != C_REG_ZERO) && (WriteReg_ME == Rs_EX)) begin
            FwdA_EX = FWD_ME;
        end
        if (RegWrite_ME && (WriteReg_ME != C_REG_ZERO) && (WriteReg_ME == Rt_EX)) begin
            FwdB_EX = FWD_ME;
        end
    end

`ifdef HAZARD_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Count stalled and flushed cycles, holding at all-ones instead of
    // wrapping so a long run never reports a small value.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Stall_ID && (stall_cnt_q != C_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + C_CNT_ONE;
        end
        if ((Flush_ID || Flush_EX) && (flush_cnt_q != C_CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + C_CNT_ONE;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule : hazard_unit
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Directed self-checking bench for hazard_unit (MDU_LAT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int REG_W   = 5;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 2;

    logic             clk;
    logic             reset;
    logic [REG_W-1:0] Rs_ID, Rt_ID, Rs_EX, Rt_EX, WriteReg_EX, WriteReg_ME;
    logic             UsesRt_ID, MduUse_ID, RegWrite_EX, MemToReg_EX, RegWrite_ME;
    logic             MduStart_EX, Jump_ID, BranchTaken_EX;
    logic             Stall_IF, Stall_ID, Flush_ID, Flush_EX, MduBusy, AnyStall;
    logic [1:0]       FwdA_EX, FwdB_EX;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] StallCnt, FlushCnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    hazard_unit #(
        .REG_W   (REG_W),
        .MDU_LAT (MDU_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .Rs_ID          (Rs_ID),
        .Rt_ID          (Rt_ID),
        .UsesRt_ID      (UsesRt_ID),
        .MduUse_ID      (MduUse_ID),
        .Rs_EX          (Rs_EX),
        .Rt_EX          (Rt_EX),
        .WriteReg_EX    (WriteReg_EX),
        .RegWrite_EX    (RegWrite_EX),
        .MemToReg_EX    (MemToReg_EX),
        .WriteReg_ME    (WriteReg_ME),
        .RegWrite_ME    (RegWrite_ME),
        .MduStart_EX    (MduStart_EX),
        .Jump_ID        (Jump_ID),
        .BranchTaken_EX (BranchTaken_EX),
        .Stall_IF       (Stall_IF),
        .Stall_ID       (Stall_ID),
        .Flush_ID       (Flush_ID),
        .Flush_EX       (Flush_EX),
        .FwdA_EX        (FwdA_EX),
        .FwdB_EX        (FwdB_EX),
        .MduBusy        (MduBusy),
        .AnyStall       (AnyStall)
`ifdef HAZARD_PERF_EN
        ,
        .StallCnt       (StallCnt),
        .FlushCnt       (FlushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return every pipeline input to a quiet value.
    task automatic clear_inputs();
        Rs_ID = '0; Rt_ID = '0; UsesRt_ID = 1'b0; MduUse_ID = 1'b0;
        Rs_EX = '0; Rt_EX = '0; WriteReg_EX = '0; RegWrite_EX = 1'b0; MemToReg_EX = 1'b0;
        WriteReg_ME = '0; RegWrite_ME = 1'b0;
        MduStart_EX = 1'b0; Jump_ID = 1'b0; BranchTaken_EX = 1'b0;
    endtask

    // {Stall_IF, Stall_ID, Flush_ID, Flush_EX, AnyStall, MduBusy}
    function automatic logic [5:0] ctl();
        return {Stall_IF, Stall_ID, Flush_ID, Flush_EX, AnyStall, MduBusy};
    endfunction

    task automatic test_reset();
        logic [5:0] got;
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        got = ctl();
        n_cmp++;
        if (got !== 6'b000000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want %b", got, 6'b000000);
        end
        n_cmp++;
        if ({FwdA_EX, FwdB_EX} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_fwd: got %b want %b", {FwdA_EX, FwdB_EX}, 4'b0000);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_load_use();
        logic [5:0] got;
        // lw $2 in EX, ID reads $2 as rs
        @(negedge clk);
        clear_inputs();
        RegWrite_EX = 1'b1; MemToReg_EX = 1'b1; WriteReg_EX = 5'd2; Rs_ID = 5'd2;
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b110110) begin
            n_bad++;
            $display("FAIL load_use_rs: got %b want %b", got, 6'b110110);
        end
        // next cycle the load has moved on: no stall
        @(negedge clk);
        clear_inputs();
        Rs_ID = 5'd2;
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b000000) begin
            n_bad++;
            $display("FAIL load_use_release: got %b want %b", got, 6'b000000);
        end
        // load into $0 never stalls
        @(negedge clk);
        RegWrite_EX = 1'b1; MemToReg_EX = 1'b1; WriteReg_EX = 5'd0; Rs_ID = 5'd0;
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b000000) begin
            n_bad++;
            $display("FAIL load_use_r0: got %b want %b", got, 6'b000000);
        end
        // match on rt only counts when rt is a real operand
        @(negedge clk);
        WriteReg_EX = 5'd7; Rs_ID = 5'd3; Rt_ID = 5'd7; UsesRt_ID = 1'b1;
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b110110) begin
            n_bad++;
            $display("FAIL load_use_rt: got %b want %b", got, 6'b110110);
        end
        @(negedge clk);
        UsesRt_ID = 1'b0;
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b000000) begin
            n_bad++;
            $display("FAIL load_use_rt_unused: got %b want %b", got, 6'b000000);
        end
        // non-load producer: forwarding covers it, no stall
        @(negedge clk);
        UsesRt_ID = 1'b1; MemToReg_EX = 1'b0;
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b000000) begin
            n_bad++;
            $display("FAIL load_use_alu: got %b want %b", got, 6'b000000);
        end
    endtask

    task automatic test_forward();
        @(negedge clk);
        clear_inputs();
        RegWrite_ME = 1'b1; WriteReg_ME = 5'd5; Rs_EX = 5'd5; Rt_EX = 5'd5;
        #1;
        n_cmp++;
        if ({FwdA_EX, FwdB_EX} !== 4'b0101) begin
            n_bad++;
            $display("FAIL fwd_both: got %b want %b", {FwdA_EX, FwdB_EX}, 4'b0101);
        end
        @(negedge clk);
        WriteReg_ME = 5'd0; Rs_EX = 5'd0; Rt_EX = 5'd0;
        #1;
        n_cmp++;
        if ({FwdA_EX, FwdB_EX} !== 4'b0000) begin
            n_bad++;
            $display("FAIL fwd_r0: got %b want %b", {FwdA_EX, FwdB_EX}, 4'b0000);
        end
        @(negedge clk);
        WriteReg_ME = 5'd9; Rs_EX = 5'd4; Rt_EX = 5'd9;
        #1;
        n_cmp++;
        if ({FwdA_EX, FwdB_EX} !== 4'b0001) begin
            n_bad++;
            $display("FAIL fwd_rt_only: got %b want %b", {FwdA_EX, FwdB_EX}, 4'b0001);
        end
        @(negedge clk);
        Rs_EX = 5'd9; Rt_EX = 5'd4;
        #1;
        n_cmp++;
        if ({FwdA_EX, FwdB_EX} !== 4'b0100) begin
            n_bad++;
            $display("FAIL fwd_rs_only: got %b want %b", {FwdA_EX, FwdB_EX}, 4'b0100);
        end
        @(negedge clk);
        RegWrite_ME = 1'b0; Rt_EX = 5'd9;
        #1;
        n_cmp++;
        if ({FwdA_EX, FwdB_EX} !== 4'b0000) begin
            n_bad++;
            $display("FAIL fwd_no_write: got %b want %b", {FwdA_EX, FwdB_EX}, 4'b0000);
        end
    endtask

    task automatic test_redirect();
        logic [5:0] got;
        @(negedge clk);
        clear_inputs();
        RegWrite_EX = 1'b1; MemToReg_EX = 1'b1; WriteReg_EX = 5'd2; Rs_ID = 5'd2;
        BranchTaken_EX = 1'b1;
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b001100) begin
            n_bad++;
            $display("FAIL branch_over_loaduse: got %b want %b", got, 6'b001100);
        end
        @(negedge clk);
        clear_inputs();
        Jump_ID = 1'b1;
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b001000) begin
            n_bad++;
            $display("FAIL jump_only: got %b want %b", got, 6'b001000);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_mdu();
        logic [5:0] got;
        @(negedge clk);
        clear_inputs();
        MduStart_EX = 1'b1;
        #1;
        n_cmp++;
        if (MduBusy !== 1'b0) begin
            n_bad++;
            $display("FAIL mdu_idle_at_start: got %b want %b", MduBusy, 1'b0);
        end
        for (int i = 0; i < MDU_LAT - 1; i++) begin
            @(negedge clk);
            MduStart_EX = 1'b0; MduUse_ID = 1'b1;
            #1; got = ctl();
            n_cmp++;
            if (got !== 6'b110111) begin
                n_bad++;
                $display("FAIL mdu_stall_cycle%0d: got %b want %b", i, got, 6'b110111);
            end
        end
        @(negedge clk);
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b000000) begin
            n_bad++;
            $display("FAIL mdu_release: got %b want %b", got, 6'b000000);
        end
        // flushes do not cancel the MDU op; branch only masks the stall
        @(negedge clk);
        MduUse_ID = 1'b0; MduStart_EX = 1'b1;
        @(negedge clk);
        MduStart_EX = 1'b0; BranchTaken_EX = 1'b1; MduUse_ID = 1'b1;
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b001101) begin
            n_bad++;
            $display("FAIL mdu_branch_mask: got %b want %b", got, 6'b001101);
        end
        @(negedge clk);
        BranchTaken_EX = 1'b0;
        #1;
        n_cmp++;
        if (MduBusy !== 1'b1) begin
            n_bad++;
            $display("FAIL mdu_survives_flush: got %b want %b", MduBusy, 1'b1);
        end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_mdu_reset();
        logic [5:0] got;
        @(negedge clk);
        clear_inputs();
        MduStart_EX = 1'b1;
        @(negedge clk);
        MduStart_EX = 1'b0; MduUse_ID = 1'b1;
        #1;
        n_cmp++;
        if (MduBusy !== 1'b1) begin
            n_bad++;
            $display("FAIL mdu_busy_before_reset: got %b want %b", MduBusy, 1'b1);
        end
        #1 reset = 1'b0;
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b000000) begin
            n_bad++;
            $display("FAIL mdu_async_reset: got %b want %b", got, 6'b000000);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1; got = ctl();
            n_cmp++;
            if (got !== 6'b000000) begin
                n_bad++;
                $display("FAIL mdu_after_reset%0d: got %b want %b", i, got, 6'b000000);
            end
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [5:0] got;
        @(negedge clk);
        clear_inputs();
        MduStart_EX = 1'b1;
        @(negedge clk);
        MduStart_EX = 1'b0; MduUse_ID = 1'b1;
        RegWrite_EX = 1'b1; MemToReg_EX = 1'b1; WriteReg_EX = 5'd6; Rs_ID = 5'd6;
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b110111) begin
            n_bad++;
            $display("FAIL combined_stall: got %b want %b", got, 6'b110111);
        end
        @(negedge clk);
        RegWrite_EX = 1'b0; MemToReg_EX = 1'b0;
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b110111) begin
            n_bad++;
            $display("FAIL combined_mdu_tail: got %b want %b", got, 6'b110111);
        end
        repeat (2) @(negedge clk);
        #1; got = ctl();
        n_cmp++;
        if (got !== 6'b000000) begin
            n_bad++;
            $display("FAIL combined_release: got %b want %b", got, 6'b000000);
        end
        clear_inputs();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        RegWrite_EX = 1'b1; MemToReg_EX = 1'b1; WriteReg_EX = 5'd2; Rs_ID = 5'd2;
        repeat (5) @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (StallCnt !== 2'd3) begin
            n_bad++;
            $display("FAIL perf_stall_sat: got %0d want %0d", StallCnt, 3);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        Jump_ID = 1'b1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        #1;
        n_cmp++;
        if (FlushCnt !== 2'd1) begin
            n_bad++;
            $display("FAIL perf_flush_one: got %0d want %0d", FlushCnt, 1);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        reset = 1'b0;
        test_reset();
        test_load_use();
        test_forward();
        test_redirect();
        test_mdu();
        test_mdu_reset();
        test_back_to_back();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute bound so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule : tb_hazard_unit
`default_nettype wire
